// File: rtl/xcore_gnrl_pkg.sv
// Shared constants for the general round-robin grant generator.
package xcore_gnrl_pkg;

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_BUSY     = 1'b1;
    localparam int   TIMEOUT_DEF = 16;

endpackage

// File: rtl/xcore_gnrl_rr_pick.sv
// Round-robin pick: rotates req so that last_ptr+1 lands at bit 0, then takes the lowest set bit.
module xcore_gnrl_rr_pick #(
    parameter int REQNUM = 4,
    parameter int IDXW   = 2
) (
    input  logic [REQNUM-1:0] req,
    input  logic [IDXW-1:0]   last_ptr,
    output logic [REQNUM-1:0] win_oh,
    output logic [IDXW-1:0]   win_idx,
    output logic              any
);

    logic [2*REQNUM-1:0] dbl;
    logic [2*REQNUM-1:0] shf;
    logic [REQNUM-1:0]   rot;
    logic                found;
    int unsigned         start;
    int unsigned         pos;

    always_comb begin
        dbl     = {req, req};
        start   = (int'(last_ptr) + 1) % REQNUM;
        shf     = dbl >> start;
        rot     = shf[REQNUM-1:0];
        found   = 1'b0;
        pos     = 0;
        win_oh  = '0;
        win_idx = '0;
        // Offset k in the rotated vector maps back to source (start + k) mod REQNUM.
        for (int unsigned k = 0; k < REQNUM; k++) begin
            if (!found && rot[k]) begin
                found   = 1'b1;
                pos     = (start + k) % REQNUM;
                win_idx = IDXW'(pos);
                win_oh  = REQNUM'(1) << pos;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/xcore_gnrl_rr_grant.sv
// Registered one-hot round-robin grant for the AND-OR arbiter mux select.
// Optional forced revoke of a stuck owner: define XCORE_ARB_TIMEOUT_EN.
module xcore_gnrl_rr_grant
    import xcore_gnrl_pkg::*;
#(
    parameter int REQNUM  = 4,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQNUM-1:0] req,
    input  logic              rls,
    output logic [REQNUM-1:0] gnt,
    output logic              gnt_vld,
    output logic [IDXW-1:0]   gnt_idx,
    output logic              tmo
);

    logic              state_q, state_d;
    logic [REQNUM-1:0] gnt_q, gnt_d;
    logic              vld_q, vld_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [REQNUM-1:0] win_oh;
    logic [IDXW-1:0]   win_idx;
    logic              any;
    logic              release_now;

    xcore_gnrl_rr_pick #(
        .REQNUM (REQNUM),
        .IDXW   (IDXW)
    ) u_pick (
        .req      (req),
        .last_ptr (last_q),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .any      (any)
    );

`ifdef XCORE_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
    logic            expire;

    assign expire = (state_q == ST_BUSY) && !rls && (cnt_q == CNTW'(TIMEOUT - 1));
`else
    logic expire;

    assign expire = 1'b0;
`endif

    assign release_now = (state_q == ST_BUSY) && (rls || expire);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (state_q == ST_IDLE) begin
            if (any) begin
                state_d = ST_BUSY;
                gnt_d   = win_oh;
                vld_d   = 1'b1;
                idx_d   = win_idx;
            end
        end else if (release_now) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
            idx_d   = '0;
            last_d  = idx_q;
        end
    end

`ifdef XCORE_ARB_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = expire;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (!release_now) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            last_q  <= IDXW'(REQNUM - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // The mux downstream relies on a never-multi-hot select.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_q) && (vld_q == (|gnt_q)) && (TIMEOUT >= 2));
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = vld_q;
    assign gnt_idx = idx_q;

endmodule

// File: doc/xcore_gnrl_rr_grant.md
Name: xcore_gnrl_rr_grant

Overview:
- Round-robin grant generator that drives the one-hot select (scl) of the general AND-OR arbiter mux.
- Accepts per-source requests, registers exactly one one-hot grant, and holds it until the owner releases.
- Only the selected source's data reaches the mux output, so the mux never sees a multi-hot select.
- Sits directly upstream of the mux in the shared-resource paths (bus/writeback sharing).

Parameters:
- REQNUM, 4, number of requesters; width of req and gnt; must be >= 2.
- IDXW, 2, width of gnt_idx; must satisfy 2**IDXW >= REQNUM.
- TIMEOUT, 16, busy-cycle limit used only when the optional feature is compiled in; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  REQNUM  request vector, bit i = source i wants the resource.
- rls  input  1  release pulse from the current owner; valid only in BUSY.
- gnt  output  REQNUM  registered one-hot grant; connects to mux scl.
- gnt_vld  output  1  high while gnt is non-zero.
- gnt_idx  output  IDXW  binary index of the granted source; 0 when idle.
- tmo  output  1  one-cycle pulse on forced revoke; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset is synchronous, active-high, on clk only, and takes priority over everything, including an in-flight grant:
  - gnt=0, gnt_vld=0, gnt_idx=0, tmo=0, state=IDLE.
  - last_ptr=REQNUM-1, so source 0 has the highest priority first.
- Two-state FSM: IDLE, BUSY.
- IDLE:
  - If |req is 0, stay in IDLE with outputs at 0.
  - Otherwise pick the first set req bit, scanning from last_ptr+1 upward and wrapping from REQNUM-1 to 0.
  - Next cycle: gnt = onehot(winner), gnt_idx = winner, gnt_vld = 1, state = BUSY.
  - Latency: req sampled at edge t gives gnt at t+1.
- BUSY:
  - gnt, gnt_idx and gnt_vld are held stable regardless of req changes; the owner dropping req does not revoke.
  - Other requests wait.
  - On rls=1: next cycle gnt=0, gnt_vld=0, gnt_idx=0, last_ptr=winner, state=IDLE.
  - Minimum gap between consecutive grants is one idle cycle: rls at t, gnt=0 at t+1, next gnt at t+2.
- Boundary conditions:
  - rls while IDLE is ignored.
  - rls together with new req in the same cycle: release only; arbitration happens in the following IDLE cycle.
  - Winner equal to last_ptr is allowed when it is the only requester, e.g. the same source is granted repeatedly.
  - Wrap-around: last_ptr=REQNUM-1 scans starting at 0.
- gnt is never multi-hot. Assertion: $onehot0(gnt) every cycle, and gnt_vld == |gnt.
- All outputs are registered; there is no combinational path from req or rls to gnt.

Optional Feature:
- Macro: XCORE_ARB_TIMEOUT_EN.
- Defined:
  - A busy counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT-1 with no rls, the grant is force-released exactly as for rls: last_ptr=winner, state=IDLE, gnt=0 next cycle.
  - tmo pulses high for that one cycle.
  - rls in the same cycle as expiry counts as a normal release, with tmo=0.
- Undefined: no counter is built, tmo is tied to 0, and BUSY is held indefinitely until rls.

Decomposition:
- Shared package xcore_gnrl_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_BUSY=1'b1;
  - the default TIMEOUT constant.
- One natural combinational sub-module, xcore_gnrl_rr_pick:
  - inputs: req, last_ptr;
  - outputs: winner one-hot, winner index, any.
  - Implementation: double-width rotate-and-priority-encode.
- The top module holds the FSM, registers, last_ptr and the optional counter.

Test Plan:
- Reset: assert rst for 2 cycles while in BUSY with gnt=0100 -> next cycle gnt=0, gnt_vld=0, gnt_idx=0, tmo=0; then req=1111 -> gnt=0001.
- Single requester: req=0100 -> gnt=0100 and gnt_idx=2 one cycle later; rls pulse -> gnt=0 next cycle; req still 0100 -> gnt=0100 again.
- Rotation: req=1111 held, rls issued each BUSY cycle -> grant sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between each.
- Fairness skip: after owner 2 releases, req=1011 -> gnt=1000; after that release -> gnt=0001.
- Stability and ignored release:
  - rls=1 while IDLE with req=0 -> no change.
  - In BUSY, owner drops req and other reqs toggle -> gnt unchanged until rls.
- Timeout (with XCORE_ARB_TIMEOUT_EN, TIMEOUT=4): grant 0001 with no rls -> tmo=1 for one cycle after 4 BUSY cycles, gnt=0 next cycle, then req=0011 -> gnt=0010.
